// File: rtl/rv_mdu_cfg.sv
// rv_mdu_cfg: RV32M/RV64M multiply-divide unit for the execute stage.
//
// Purpose:
//   Stall-based MDU. Multiplies run through a MUL_STAGES deep pipeline whose
//   last stage is the result register. Divides run XLEN/DIV_BITS restoring
//   iterations, one per cycle. Divide-by-zero and signed overflow finish in
//   the request cycle.
//
// Handshake:
//   The core raises mdu_req_i with a valid opcode and operands and holds them
//   stable while mdu_stall_req_o is high. mdu_result_o is valid in the first
//   cycle mdu_stall_req_o is low (state DONE). mdu_kill_i aborts at any time;
//   mdu_keep_i freezes DONE.
//
// Ports:
//   clk_i            clock, rising edge
//   arstn_i          asynchronous active-low reset
//   mdu_req_i        operation request
//   mdu_port_a_i     operand A (rs1), XLEN bits
//   mdu_port_b_i     operand B (rs2), XLEN bits
//   mdu_op_i         opcode (rv_mdu_pkg::MDU_OP_*), codes >= 8 are invalid
//   mdu_kill_i       abort current operation
//   mdu_keep_i       hold completed result in DONE
//   mdu_result_o     result register, XLEN bits
//   mdu_stall_req_o  stall request while operation incomplete
//   mdu_dbg_state_o  current FSM state, for debug and checkers

package rv_mdu_pkg;
    localparam int MDU_OP_W = 4;
    localparam logic [MDU_OP_W-1:0] MDU_OP_MUL    = 4'd0;
    localparam logic [MDU_OP_W-1:0] MDU_OP_MULH   = 4'd1;
    localparam logic [MDU_OP_W-1:0] MDU_OP_MULHSU = 4'd2;
    localparam logic [MDU_OP_W-1:0] MDU_OP_MULHU  = 4'd3;
    localparam logic [MDU_OP_W-1:0] MDU_OP_DIV    = 4'd4;
    localparam logic [MDU_OP_W-1:0] MDU_OP_DIVU   = 4'd5;
    localparam logic [MDU_OP_W-1:0] MDU_OP_REM    = 4'd6;
    localparam logic [MDU_OP_W-1:0] MDU_OP_REMU   = 4'd7;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} mdu_state_e;
endpackage

module rv_mdu_cfg
    import rv_mdu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2,
    parameter int DIV_BITS   = 1
) (
    input  logic                clk_i,
    input  logic                arstn_i,
    input  logic                mdu_req_i,
    input  logic [XLEN-1:0]     mdu_port_a_i,
    input  logic [XLEN-1:0]     mdu_port_b_i,
    input  logic [MDU_OP_W-1:0] mdu_op_i,
    input  logic                mdu_kill_i,
    input  logic                mdu_keep_i,
    output logic [XLEN-1:0]     mdu_result_o,
    output logic                mdu_stall_req_o,
    output mdu_state_e          mdu_dbg_state_o
);

    localparam int N     = XLEN / DIV_BITS;
    localparam int CNT_W = $clog2(N + 1) + 1;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STAGES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(N);

    mdu_state_e       r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic [XLEN-1:0]  r_result, w_res_d;
    logic             w_res_we;
    logic             w_div_start;

    // ---------------- opcode decode ----------------
    logic w_op_valid, w_is_mul, w_div_signed, w_div_rem;
    logic w_a_sgn, w_b_sgn, w_b_zero, w_ovf;

    assign w_op_valid   = ~mdu_op_i[3];
    assign w_is_mul     = ~mdu_op_i[2];
    assign w_div_signed = (mdu_op_i == MDU_OP_DIV) | (mdu_op_i == MDU_OP_REM);
    assign w_div_rem    = mdu_op_i[1];
    assign w_a_sgn      = (mdu_op_i == MDU_OP_MUL) | (mdu_op_i == MDU_OP_MULH) |
                          (mdu_op_i == MDU_OP_MULHSU);
    assign w_b_sgn      = (mdu_op_i == MDU_OP_MUL) | (mdu_op_i == MDU_OP_MULH);
    assign w_b_zero     = (mdu_port_b_i == '0);
    assign w_ovf        = w_div_signed & (mdu_port_a_i == {1'b1, {(XLEN-1){1'b0}}}) &
                          (mdu_port_b_i == '1);

    // Early-resolved divide result: B=0 gives all ones / A, overflow gives A / 0.
    logic [XLEN-1:0] w_spec_res;
    assign w_spec_res = w_b_zero ? (w_div_rem ? mdu_port_a_i : '1)
                                 : (w_div_rem ? '0 : mdu_port_a_i);

    // ---------------- multiplier ----------------
    // Extending to 2*XLEN is enough: the low 2*XLEN bits of a modular product
    // are identical to those of the XLEN+1 bit signed/unsigned product.
    logic [2*XLEN-1:0] w_a_ext, w_b_ext, w_prod;
    logic [XLEN-1:0]   w_mul_res, w_mul_out;

    assign w_a_ext   = {{XLEN{w_a_sgn & mdu_port_a_i[XLEN-1]}}, mdu_port_a_i};
    assign w_b_ext   = {{XLEN{w_b_sgn & mdu_port_b_i[XLEN-1]}}, mdu_port_b_i};
    assign w_prod    = w_a_ext * w_b_ext;
    assign w_mul_res = (mdu_op_i == MDU_OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    // The result register acts as the final multiplier stage, so only
    // MUL_STAGES-1 internal registers are needed.
    if (MUL_STAGES > 1) begin : g_pipe
        logic [XLEN-1:0] r_pipe [MUL_STAGES-1];
        always_ff @(posedge clk_i or negedge arstn_i) begin
            if (!arstn_i) begin
                for (int k = 0; k < MUL_STAGES-1; k++) r_pipe[k] <= '0;
            end else begin
                r_pipe[0] <= w_mul_res;
                for (int k = 1; k < MUL_STAGES-1; k++) r_pipe[k] <= r_pipe[k-1];
            end
        end
        assign w_mul_out = r_pipe[MUL_STAGES-2];
    end else begin : g_nopipe
        assign w_mul_out = w_mul_res;
    end

    // ---------------- divider ----------------
    logic [XLEN-1:0] r_rem, r_quo, r_dvs;
    logic            r_neg_q, r_neg_r, r_is_rem;
    logic [XLEN-1:0] w_a_abs, w_b_abs;
    logic [XLEN:0]   w_rem_n;
    logic [XLEN-1:0] w_quo_n, w_rem_lo, w_q_fix, w_r_fix, w_div_res;

    assign w_a_abs = (w_div_signed & mdu_port_a_i[XLEN-1]) ? -mdu_port_a_i : mdu_port_a_i;
    assign w_b_abs = (w_div_signed & mdu_port_b_i[XLEN-1]) ? -mdu_port_b_i : mdu_port_b_i;

    // DIV_BITS restoring steps per cycle; quotient bits shift in at the LSB
    // while dividend bits shift out of the MSB into the partial remainder.
    always_comb begin
        w_rem_n = {1'b0, r_rem};
        w_quo_n = r_quo;
        for (int i = 0; i < DIV_BITS; i++) begin
            w_rem_n = {w_rem_n[XLEN-1:0], w_quo_n[XLEN-1]};
            w_quo_n = {w_quo_n[XLEN-2:0], 1'b0};
            if (w_rem_n >= {1'b0, r_dvs}) begin
                w_rem_n    = w_rem_n - {1'b0, r_dvs};
                w_quo_n[0] = 1'b1;
            end
        end
    end

    assign w_rem_lo  = w_rem_n[XLEN-1:0];
    assign w_q_fix   = r_neg_q ? -w_quo_n : w_quo_n;
    assign w_r_fix   = r_neg_r ? -w_rem_lo : w_rem_lo;
    assign w_div_res = r_is_rem ? w_r_fix : w_q_fix;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_rem <= 1'b0;
        end else if (w_div_start) begin
            r_rem    <= '0;
            r_quo    <= w_a_abs;
            r_dvs    <= w_b_abs;
            r_neg_q  <= w_div_signed & (mdu_port_a_i[XLEN-1] ^ mdu_port_b_i[XLEN-1]);
            r_neg_r  <= w_div_signed & mdu_port_a_i[XLEN-1];
            r_is_rem <= w_div_rem;
        end else if (r_state == ST_DIV) begin
            r_rem <= w_rem_lo;
            r_quo <= w_quo_n;
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            if (w_res_we) r_result <= w_res_d;
        end
    end

    // r_cnt holds the cycle index relative to the request cycle.
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_res_we    = 1'b0;
        w_res_d     = r_result;
        w_div_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mdu_req_i && w_op_valid) begin
                    w_cnt_n = CNT_W'(1);
                    if (w_is_mul) begin
                        if (MUL_STAGES == 1) begin
                            w_state_n = ST_DONE;
                            w_res_we  = 1'b1;
                            w_res_d   = w_mul_res;
                        end else begin
                            w_state_n = ST_MUL;
                        end
                    end else if (w_b_zero || w_ovf) begin
                        w_state_n = ST_DONE;
                        w_res_we  = 1'b1;
                        w_res_d   = w_spec_res;
                    end else begin
                        w_state_n   = ST_DIV;
                        w_div_start = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (r_cnt == MUL_LAST) begin
                    w_state_n = ST_DONE;
                    w_res_we  = 1'b1;
                    w_res_d   = w_mul_out;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            ST_DIV: begin
                if (r_cnt == DIV_LAST) begin
                    w_state_n = ST_DONE;
                    w_res_we  = 1'b1;
                    w_res_d   = w_div_res;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (!mdu_keep_i) w_state_n = ST_IDLE;
            end
            default: w_state_n = ST_IDLE;
        endcase
        // Kill overrides everything: no start, no result write.
        if (mdu_kill_i) begin
            w_state_n   = ST_IDLE;
            w_res_we    = 1'b0;
            w_div_start = 1'b0;
        end
    end

    assign mdu_stall_req_o = (((r_state == ST_IDLE) & mdu_req_i & w_op_valid) |
                              (r_state == ST_MUL) | (r_state == ST_DIV)) & ~mdu_kill_i;
    assign mdu_result_o    = r_result;
    assign mdu_dbg_state_o = r_state;

endmodule

// File: tb/tb_rv_mdu_cfg.sv
// Testbench for rv_mdu_cfg. Three instances cover the parameter corners:
//   d=0: MUL_STAGES=2, DIV_BITS=1
//   d=1: MUL_STAGES=1, DIV_BITS=2
//   d=2: MUL_STAGES=4, DIV_BITS=2
// Results and latencies come from a plain-arithmetic reference model.
module tb_rv_mdu_cfg;
    import rv_mdu_pkg::*;

    logic        clk;
    logic        arstn;
    logic        req   [3];
    logic [31:0] pa    [3];
    logic [31:0] pb    [3];
    logic [3:0]  op    [3];
    logic        kill  [3];
    logic        keep  [3];
    logic [31:0] result[3];
    logic        stall [3];
    mdu_state_e  st    [3];

    int cfg_s  [3] = '{2, 1, 4};
    int cfg_db [3] = '{1, 2, 2};

    int n_tests = 0;
    int n_fail  = 0;

    rv_mdu_cfg #(.XLEN(32), .MUL_STAGES(2), .DIV_BITS(1)) u_dut0 (
        .clk_i(clk), .arstn_i(arstn), .mdu_req_i(req[0]), .mdu_port_a_i(pa[0]),
        .mdu_port_b_i(pb[0]), .mdu_op_i(op[0]), .mdu_kill_i(kill[0]), .mdu_keep_i(keep[0]),
        .mdu_result_o(result[0]), .mdu_stall_req_o(stall[0]), .mdu_dbg_state_o(st[0]));

    rv_mdu_cfg #(.XLEN(32), .MUL_STAGES(1), .DIV_BITS(2)) u_dut1 (
        .clk_i(clk), .arstn_i(arstn), .mdu_req_i(req[1]), .mdu_port_a_i(pa[1]),
        .mdu_port_b_i(pb[1]), .mdu_op_i(op[1]), .mdu_kill_i(kill[1]), .mdu_keep_i(keep[1]),
        .mdu_result_o(result[1]), .mdu_stall_req_o(stall[1]), .mdu_dbg_state_o(st[1]));

    rv_mdu_cfg #(.XLEN(32), .MUL_STAGES(4), .DIV_BITS(2)) u_dut2 (
        .clk_i(clk), .arstn_i(arstn), .mdu_req_i(req[2]), .mdu_port_a_i(pa[2]),
        .mdu_port_b_i(pb[2]), .mdu_op_i(op[2]), .mdu_kill_i(kill[2]), .mdu_keep_i(keep[2]),
        .mdu_result_o(result[2]), .mdu_stall_req_o(stall[2]), .mdu_dbg_state_o(st[2]));

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_res(input logic [3:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            MDU_OP_MUL:    begin p = ua * ub;          return p[31:0];  end
            MDU_OP_MULH:   begin p = sa * sb;          return p[63:32]; end
            MDU_OP_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            MDU_OP_MULHU:  begin p = ua * ub;          return p[63:32]; end
            MDU_OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            MDU_OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            MDU_OP_REM:    return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            MDU_OP_REMU:   return (b == 0) ? a : 32'(ua % ub);
            default:       return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input int d, input logic [3:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
        logic signed_op;
        signed_op = (o == MDU_OP_DIV) || (o == MDU_OP_REM);
        if (o < 4) return cfg_s[d];
        if (b == 0) return 1;
        if (signed_op && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 32 / cfg_db[d] + 1;
    endfunction

    // ---------------- driver tasks ----------------
    // Called #1 after the posedge of the request cycle; returns at the negedge
    // of the first cycle with stall low. lat = number of stalled cycles.
    task automatic wait_done(input int d, output int lat);
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!stall[d]) break;
            lat++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_op(input int d, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        int          lat;
        logic [31:0] e;
        e = ref_res(o, a, b);
        @(posedge clk);
        #1;
        req[d] = 1'b1;
        op[d]  = o;
        pa[d]  = a;
        pb[d]  = b;
        wait_done(d, lat);
        chk({tag, "_lat"}, 64'(lat), 64'(ref_lat(d, o, a, b)));
        chk({tag, "_res"}, 64'(result[d]), 64'(e));
        req[d] = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int          lat;
        logic [31:0] prev;
        arstn = 1'b0;
        for (int d = 0; d < 3; d++) begin
            req[d] = 0; pa[d] = 0; pb[d] = 0; op[d] = 0; kill[d] = 0; keep[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_res%0d", d), 64'(result[d]), 64'd0);
            chk($sformatf("rst_stall%0d", d), 64'(stall[d]), 64'd0);
            chk($sformatf("rst_state%0d", d), 64'(st[d]), 64'(ST_IDLE));
        end
        @(negedge clk);
        arstn = 1'b1;

        // Multiply corners on all three pipeline depths.
        for (int d = 0; d < 3; d++) begin
            run_op(d, MDU_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, $sformatf("mulhu%0d", d));
            run_op(d, MDU_OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, $sformatf("mulh%0d", d));
            run_op(d, MDU_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, $sformatf("mulhsu%0d", d));
            run_op(d, MDU_OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, $sformatf("mul%0d", d));
        end

        // Divide basics on radix-2 and radix-4 builds.
        for (int d = 0; d < 2; d++) begin
            run_op(d, MDU_OP_DIV,  32'hFFFF_FFF9, 32'd2, $sformatf("div%0d", d));
            run_op(d, MDU_OP_REM,  32'hFFFF_FFF9, 32'd2, $sformatf("rem%0d", d));
            run_op(d, MDU_OP_DIVU, 32'd100, 32'd7, $sformatf("divu%0d", d));
            run_op(d, MDU_OP_REMU, 32'd100, 32'd7, $sformatf("remu%0d", d));
        end

        // Early-resolved special cases.
        run_op(0, MDU_OP_DIVU, 32'd5, 32'd0, "divu_by0");
        run_op(0, MDU_OP_REMU, 32'd5, 32'd0, "remu_by0");
        run_op(0, MDU_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(0, MDU_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        run_op(2, MDU_OP_DIV,  32'h1234_5678, 32'd0, "div_by0_d2");

        // Kill in cycle 10 of a divide.
        prev = result[0];
        @(posedge clk);
        #1;
        req[0] = 1'b1; op[0] = MDU_OP_DIV; pa[0] = 32'd1000; pb[0] = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        kill[0] = 1'b1;
        @(negedge clk);
        chk("kill_stall", 64'(stall[0]), 64'd0);
        @(posedge clk);
        #1;
        req[0] = 1'b0; kill[0] = 1'b0;
        @(negedge clk);
        chk("kill_state", 64'(st[0]), 64'(ST_IDLE));
        chk("kill_res", 64'(result[0]), 64'(prev));
        run_op(0, MDU_OP_MUL, 32'd3, 32'd4, "mul_after_kill");

        // Keep held in DONE, then re-execution of the held request.
        @(posedge clk);
        #1;
        req[0] = 1'b1; keep[0] = 1'b1; op[0] = MDU_OP_DIVU; pa[0] = 32'd20; pb[0] = 32'd3;
        wait_done(0, lat);
        chk("keep_lat", 64'(lat), 64'd33);
        chk("keep_res", 64'(result[0]), 64'd6);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk($sformatf("keep_hold_res%0d", k), 64'(result[0]), 64'd6);
            chk($sformatf("keep_hold_stall%0d", k), 64'(stall[0]), 64'd0);
            chk($sformatf("keep_hold_state%0d", k), 64'(st[0]), 64'(ST_DONE));
        end
        @(posedge clk);
        #1;
        keep[0] = 1'b0;
        @(negedge clk);
        chk("keep_drop_stall", 64'(stall[0]), 64'd0);
        @(posedge clk);
        #1;
        wait_done(0, lat);
        chk("rerun_lat", 64'(lat), 64'd33);
        chk("rerun_res", 64'(result[0]), 64'd6);
        req[0] = 1'b0;

        // Reset pulse in cycle 5 of a divide.
        @(posedge clk);
        #1;
        req[0] = 1'b1; op[0] = MDU_OP_DIV; pa[0] = 32'd1000; pb[0] = 32'd3;
        repeat (5) @(posedge clk);
        #1;
        arstn  = 1'b0;
        req[0] = 1'b0;
        #1;
        chk("arst_res", 64'(result[0]), 64'd0);
        chk("arst_stall", 64'(stall[0]), 64'd0);
        chk("arst_state", 64'(st[0]), 64'(ST_IDLE));
        @(negedge clk);
        arstn = 1'b1;
        run_op(0, MDU_OP_DIVU, 32'd9, 32'd3, "divu_after_rst");

        // Invalid opcode: no stall, result unchanged, stays IDLE.
        prev = result[0];
        @(posedge clk);
        #1;
        req[0] = 1'b1; op[0] = 4'($urandom_range(8, 15)); pa[0] = $urandom; pb[0] = $urandom;
        @(negedge clk);
        chk("inv_stall", 64'(stall[0]), 64'd0);
        @(posedge clk);
        #1;
        chk("inv_state", 64'(st[0]), 64'(ST_IDLE));
        chk("inv_res", 64'(result[0]), 64'(prev));
        req[0] = 1'b0;

        // Randomized operations on all instances.
        for (int t = 0; t < 90; t++) begin
            int          d;
            logic [3:0]  o;
            logic [31:0] a, b;
            d = $urandom_range(0, 2);
            o = 4'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            run_op(d, o, a, b, $sformatf("rnd%0d_d%0d_op%0d", t, d, o));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
